// File: rtl/serial_work_receiver_pkg.sv
// Shared constants and UART state encoding for the serial work receive path.
package serial_work_receiver_pkg;

    localparam int WORK_BYTES  = 44;
    localparam int MIDSTATE_W  = 256;
    localparam int DATA_TAIL_W = 96;
    localparam int WORK_W      = MIDSTATE_W + DATA_TAIL_W;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP,
        UART_WAIT_HIGH
    } uart_state_t;

endpackage

// File: rtl/serial_work_receiver_uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, mid-bit sampling FSM, stop-bit check.
module uart_rx_byte
    import serial_work_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       hash_clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       frame_err,
    output logic       line_idle
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TIMER_W-1:0] HALF_BIT = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_BIT = TIMER_W'(CLKS_PER_BIT - 1);

    uart_state_t        state;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         bit_idx;
    logic               rx_meta, rx_sync, rx_prev;

    // NOTE: synchroniser flops reset to the idle-high level so reset release never looks like a start edge.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state     <= UART_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                UART_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= UART_START;
                        timer <= '0;
                    end
                end
                UART_START: begin
                    if (timer == HALF_BIT) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? UART_IDLE : UART_DATA;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                UART_DATA: begin
                    if (timer == FULL_BIT) begin
                        timer   <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= UART_STOP;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                UART_STOP: begin
                    if (timer == FULL_BIT) begin
                        timer <= '0;
                        if (rx_sync) begin
                            rx_strobe <= 1'b1;
                            state     <= UART_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= UART_WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                UART_WAIT_HIGH: begin
                    if (rx_sync) state <= UART_IDLE;
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

    assign line_idle = (state == UART_IDLE);

endmodule

// File: rtl/serial_work_receiver.sv
// Assembles 44-byte work packets from the UART into midstate/data_tail, with abort on error or idle timeout.
module serial_work_receiver
    import serial_work_receiver_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                   hash_clk,
    input  logic                   reset,
    input  logic                   rx_serial,
    output logic [MIDSTATE_W-1:0]  midstate,
    output logic [DATA_TAIL_W-1:0] data_tail,
    output logic                   work_valid,
    output logic                   frame_err,
    output logic                   rx_busy
);

    localparam int CLKS_PER_BIT   = CLK_HZ / BAUD;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]        LAST_BYTE = 6'(WORK_BYTES - 1);
    localparam int                HELD_W    = WORK_W - 8;

    logic [7:0]        rx_byte;
    logic              rx_strobe, line_idle;
    logic [HELD_W-1:0] shift;
    logic [5:0]        byte_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [WORK_W-1:0] packet;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .hash_clk  (hash_clk),
        .reset     (reset),
        .rx_serial (rx_serial),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .frame_err (frame_err),
        .line_idle (line_idle)
    );

    // Only 43 bytes are ever held; the 44th is appended on the fly at completion.
    assign packet  = {shift, rx_byte};
    assign rx_busy = (byte_cnt != 6'd0);

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            shift      <= '0;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            midstate   <= '0;
            data_tail  <= '0;
            work_valid <= 1'b0;
        end else begin
            work_valid <= 1'b0;
            if (frame_err) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (rx_strobe) begin
                idle_cnt <= '0;
                shift    <= {shift[HELD_W-9:0], rx_byte};
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt   <= '0;
                    midstate   <= packet[WORK_W-1:DATA_TAIL_W];
                    data_tail  <= packet[DATA_TAIL_W-1:0];
                    work_valid <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 6'd1;
                end
            end else if (rx_busy && line_idle) begin
                if (idle_cnt == IDLE_LAST) begin
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serial_work_receiver.sv
// Scoreboard bench for serial_work_receiver at 16 clocks per bit.
module tb_serial_work_receiver;

    localparam int CPB        = 16;
    localparam int PKT_CYCLES = 44 * 10 * CPB;

    localparam logic [255:0] MS1 = 256'h2b3f81261b3cfd001db436cfd4c8f3f9c7450c9a0d049bee71cba0ea2619c0b5;
    localparam logic [95:0]  TL1 = 96'h39f3001b6b7b8d4dc14bfc31;
    localparam logic [255:0] MS2 = 256'h0123456789abcdeffedcba987654321000112233445566778899aabbccddeeff;
    localparam logic [95:0]  TL2 = 96'hdeadbeefcafef00da5a5a5a5;
    localparam logic [255:0] MS3 = 256'hffeeddccbbaa998877665544332211000f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [95:0]  TL3 = 96'h0102030405060708090a0b0c;
    localparam logic [255:0] MS5 = 256'h8000000000000000000000000000000000000000000000000000000000000001;
    localparam logic [95:0]  TL5 = 96'h0000000000000001c8a00001;

    logic         hash_clk  = 1'b0;
    logic         reset     = 1'b1;
    logic         rx_serial = 1'b1;
    logic [255:0] midstate;
    logic [95:0]  data_tail;
    logic         work_valid, frame_err, rx_busy;

    typedef struct {
        logic [255:0] ms;
        logic [95:0]  tail;
    } work_t;

    work_t exp_q[$];
    int    valid_cyc[$];
    int    checks    = 0;
    int    passed    = 0;
    int    valid_cnt = 0;
    int    fe_cycles = 0;
    int    cyc       = 0;

    serial_work_receiver #(.CLK_HZ(1_600_000), .BAUD(100_000), .TIMEOUT_BITS(32)) dut (
        .hash_clk   (hash_clk),
        .reset      (reset),
        .rx_serial  (rx_serial),
        .midstate   (midstate),
        .data_tail  (data_tail),
        .work_valid (work_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 hash_clk = ~hash_clk;
    always @(posedge hash_clk) cyc++;

    task automatic check(input string name, input logic [351:0] act, input logic [351:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge hash_clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge hash_clk);
        end
        rx_serial = stop;
        repeat (CPB) @(negedge hash_clk);
        rx_serial = 1'b1;
    endtask

    task automatic send_bytes(input logic [255:0] ms, input logic [95:0] tail, input int first, input int n);
        logic [351:0] w;
        w = {ms, tail};
        for (int k = first; k < first + n; k++) send_byte(w[351 - 8*k -: 8]);
    endtask

    task automatic wait_valid(input int n);
        for (int i = 0; i < 8 * CPB && valid_cnt < n; i++) @(negedge hash_clk);
        check("work_valid_count", valid_cnt, n);
    endtask

    // Monitor: pops the scoreboard on every work_valid pulse.
    initial begin
        work_t e;
        forever begin
            @(negedge hash_clk);
            if (frame_err) fe_cycles++;
            if (work_valid) begin
                valid_cnt++;
                valid_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_work_valid: pulse at cycle %0d with nothing expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("midstate", midstate, e.ms);
                    check("data_tail", data_tail, e.tail);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge hash_clk);
        check("reset_midstate", midstate, 0);
        check("reset_data_tail", data_tail, 0);
        check("reset_work_valid", work_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_rx_busy", rx_busy, 0);
        reset = 1'b0;
        repeat (4 * CPB) @(negedge hash_clk);

        // 0.3 bit-time glitch on an idle line
        rx_serial = 1'b0;
        repeat (5) @(negedge hash_clk);
        rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge hash_clk);
        check("glitch_rx_busy", rx_busy, 0);
        check("glitch_frame_err", fe_cycles, 0);
        check("glitch_work_valid", valid_cnt, 0);

        // Nominal packet
        exp_q.push_back('{MS1, TL1});
        send_bytes(MS1, TL1, 0, 1);
        check("busy_after_byte1", rx_busy, 1);
        send_bytes(MS1, TL1, 1, 42);
        check("busy_after_byte43", rx_busy, 1);
        send_bytes(MS1, TL1, 43, 1);
        wait_valid(1);
        check("busy_after_packet", rx_busy, 0);

        // Framing error after 10 bytes, then a clean packet
        send_bytes(MS2, TL2, 0, 10);
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge hash_clk);
        check("frame_err_cycles", fe_cycles, 1);
        check("busy_after_frame_err", rx_busy, 0);
        check("hold_after_frame_err", midstate, MS1);
        exp_q.push_back('{MS2, TL2});
        send_bytes(MS2, TL2, 0, 44);
        wait_valid(2);

        // Timeout after 20 bytes, then a clean packet
        send_bytes(MS1, TL1, 0, 20);
        check("busy_before_timeout", rx_busy, 1);
        repeat (33 * CPB) @(negedge hash_clk);
        check("busy_after_timeout", rx_busy, 0);
        check("hold_after_timeout", midstate, MS2);
        exp_q.push_back('{MS3, TL3});
        send_bytes(MS3, TL3, 0, 44);
        wait_valid(3);

        // Back-to-back packets with no idle gap
        exp_q.push_back('{MS1, TL1});
        exp_q.push_back('{MS5, TL5});
        send_bytes(MS1, TL1, 0, 44);
        send_bytes(MS5, TL5, 0, 44);
        wait_valid(5);
        if (valid_cyc.size() >= 5) check("b2b_spacing", valid_cyc[4] - valid_cyc[3], PKT_CYCLES);
        else check("b2b_pulses_recorded", valid_cyc.size(), 5);
        check("b2b_final_data_tail", data_tail, TL5);

        // Reset in the middle of byte 6
        send_bytes(MS2, TL2, 0, 5);
        rx_serial = 1'b0;
        repeat (CPB + CPB / 2) @(negedge hash_clk);
        reset = 1'b1;
        #1;
        check("midreset_midstate", midstate, 0);
        check("midreset_data_tail", data_tail, 0);
        check("midreset_work_valid", work_valid, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_rx_busy", rx_busy, 0);
        rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge hash_clk);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge hash_clk);
        check("midreset_no_valid", valid_cnt, 5);
        check("midreset_no_frame_err", fe_cycles, 1);
        exp_q.push_back('{MS2, TL2});
        send_bytes(MS2, TL2, 0, 44);
        wait_valid(6);

        repeat (2 * CPB) @(negedge hash_clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
